// File: rtl/itoa.sv
// Integer-to-ASCII formatter: signed decimal or unsigned hex, written MSB-first into byte memory.
// Define ITOA_NUL_EN to append a 0x00 terminator after the last digit.
module itoa #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           hex,
  input  logic [DSZ-1:0] vi,
  input  logic [ASZ-1:0] dst,
  output logic           bsy,
  output logic           done,
  output logic [5:0]     len,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_a,
  output logic [7:0]     mem_d
);

  // Stack must hold the longest decimal (ceil(DSZ*log10(2))) or hex (DSZ/4) string
  localparam int DDEC  = (DSZ * 30103 + 99999) / 100000;
  localparam int DHEX  = DSZ / 4;
  localparam int DEPTH = (DDEC > DHEX) ? DDEC : DHEX;
  localparam int SPW   = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(DSZ);
  localparam logic [CW-1:0] CLAST = CW'(DSZ - 1);

  typedef enum logic [2:0] {
    IDL,
    CNV,
    SGN,
    OUT,
`ifdef ITOA_NUL_EN
    TRM,
`endif
    FIN
  } state_t;

  state_t state, nxt;

  logic           hexr;
  logic           neg;
  logic [DSZ-1:0] m;
  logic [3:0]     rem;
  logic [CW-1:0]  cnt;
  logic [SPW-1:0] sp;
  logic [5:0]     ndig;
  logic [3:0]     stk [DEPTH];

  logic           sneg;
  logic [4:0]     t;
  logic           ge;
  logic [3:0]     rnext;
  logic [DSZ-1:0] dnext;
  logic [3:0]     top;

  assign sneg = !hex && vi[DSZ-1];

  // Restoring divide by 10: quotient bits shift into m's LSBs while the dividend leaves at the MSB
  assign t     = {rem, m[DSZ-1]};
  assign ge    = (t >= 5'd10);
  assign rnext = ge ? 4'(t - 5'd10) : t[3:0];
  assign dnext = {m[DSZ-2:0], ge};
  assign top   = stk[sp - 1'b1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDL;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDL: if (start) nxt = CNV;
      CNV: begin
        if (hexr) begin
          if (m[DSZ-1:4] == '0) nxt = SGN;
        end else if (cnt == CLAST && dnext == '0) begin
          nxt = SGN;
        end
      end
      SGN: nxt = OUT;
      OUT: begin
`ifdef ITOA_NUL_EN
        if (sp == SPW'(1)) nxt = TRM;
`else
        if (sp == SPW'(1)) nxt = FIN;
`endif
      end
`ifdef ITOA_NUL_EN
      TRM: nxt = FIN;
`endif
      FIN: nxt = IDL;
      default: nxt = IDL;
    endcase
  end

  always_comb begin
    bsy    = 1'b0;
    done   = 1'b0;
    mem_we = 1'b0;
    mem_d  = 8'h00;
    case (state)
      CNV: bsy = 1'b1;
      SGN: begin
        bsy    = 1'b1;
        mem_we = neg;
        mem_d  = neg ? 8'h2d : 8'h00;
      end
      OUT: begin
        bsy    = 1'b1;
        mem_we = 1'b1;
        mem_d  = (top < 4'd10) ? (8'h30 + {4'h0, top}) : (8'h57 + {4'h0, top});
      end
`ifdef ITOA_NUL_EN
      TRM: begin
        bsy    = 1'b1;
        mem_we = 1'b1;
      end
`endif
      FIN: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hexr  <= 1'b0;
      neg   <= 1'b0;
      m     <= '0;
      rem   <= '0;
      cnt   <= '0;
      sp    <= '0;
      ndig  <= '0;
      len   <= '0;
      mem_a <= '0;
    end else begin
      case (state)
        IDL: if (start) begin
          hexr  <= hex;
          neg   <= sneg;
          m     <= sneg ? (~vi + 1'b1) : vi;
          mem_a <= dst;
          rem   <= '0;
          cnt   <= '0;
          sp    <= '0;
          ndig  <= '0;
        end
        CNV: begin
          if (hexr) begin
            m    <= m >> 4;
            sp   <= sp + 1'b1;
            ndig <= ndig + 6'd1;
          end else begin
            m <= dnext;
            if (cnt == CLAST) begin
              cnt  <= '0;
              rem  <= '0;
              sp   <= sp + 1'b1;
              ndig <= ndig + 6'd1;
            end else begin
              cnt <= cnt + 1'b1;
              rem <= rnext;
            end
          end
        end
        SGN: if (neg) mem_a <= mem_a + 1'b1;
        OUT: begin
          sp    <= sp - 1'b1;
          mem_a <= mem_a + 1'b1;
          if (sp == SPW'(1)) len <= ndig + {5'd0, neg};
        end
`ifdef ITOA_NUL_EN
        TRM: mem_a <= mem_a + 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Digit stack carries no reset; sp alone defines which entries are live
  always_ff @(posedge clk) begin
    if (state == CNV) begin
      if (hexr)               stk[sp] <= m[3:0];
      else if (cnt == CLAST)  stk[sp] <= rnext;
    end
  end

endmodule

// File: tb/tb_itoa.sv
// Self-checking bench for itoa: a write scoreboard fed by a software formatter model,
// plus per-conversion checks of latency, len and handshake behaviour.
module tb_itoa;

  localparam int ASZ = 17;
  localparam int DSZ = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           hex;
  logic [DSZ-1:0] vi;
  logic [ASZ-1:0] dst;
  logic           bsy;
  logic           done;
  logic [5:0]     len;
  logic           mem_we;
  logic [ASZ-1:0] mem_a;
  logic [7:0]     mem_d;

  typedef struct packed {
    logic [ASZ-1:0] a;
    logic [7:0]     d;
  } wr_t;

  wr_t sb[$];
  wr_t exp_wr;
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  itoa #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst), .start(start), .hex(hex), .vi(vi), .dst(dst),
    .bsy(bsy), .done(done), .len(len),
    .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d)
  );

  // Every write the DUT makes must match the next expected byte in order
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL write_unexpected: got a=%h d=%h, required no write", mem_a, mem_d);
      end else begin
        exp_wr = sb.pop_front();
        if (mem_a !== exp_wr.a || mem_d !== exp_wr.d) begin
          errors++;
          $display("[TB] FAIL write_data: got a=%h d=%h, required a=%h d=%h",
                   mem_a, mem_d, exp_wr.a, exp_wr.d);
        end
      end
    end
  end

  task automatic run_conv(input logic h, input logic [31:0] v, input logic [ASZ-1:0] a,
                          input int inject, input bit fin_start);
    logic [7:0]     chars[$];
    longint         mag;
    bit             ng;
    int             dg, nd, n, explat;
    bit             got;
    logic [ASZ-1:0] ad;
    ng  = !h && v[31];
    mag = ng ? ((longint'(1) << 32) - longint'(v)) : longint'(v);
    do begin
      if (h) begin dg = int'(mag % 16); mag = mag / 16; end
      else   begin dg = int'(mag % 10); mag = mag / 10; end
      chars.push_front(dg < 10 ? 8'(8'h30 + dg) : 8'(8'h57 + dg));
    end while (mag != 0);
    nd = chars.size();
    if (ng) chars.push_front(8'h2d);
`ifdef ITOA_NUL_EN
    chars.push_back(8'h00);
    explat = 1 + nd * (h ? 1 : DSZ) + 1 + nd + 1;
`else
    explat = 1 + nd * (h ? 1 : DSZ) + 1 + nd;
`endif
    ad = a;
    foreach (chars[i]) begin
      sb.push_back('{a: ad, d: chars[i]});
      ad = ad + 1'b1;
    end

    @(posedge clk); #1;
    start = 1'b1; hex = h; vi = v; dst = a;
    n = 0; got = 0;
    while (!got && n < 4000) begin
      @(posedge clk); #1;
      start = 1'b0;
      vi    = $urandom;
      hex   = 1'($urandom_range(0, 1));
      dst   = ASZ'($urandom);
      n++;
      if (n == inject) start = 1'b1;
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end

    checks++;
    if (!got || n != explat) begin
      errors++;
      $display("[TB] FAIL latency v=%h: got %0d cycles (done seen=%0d), required %0d", v, n, got, explat);
    end
    if (got) begin
      checks++;
      if (len !== 6'(nd + (ng ? 1 : 0))) begin
        errors++;
        $display("[TB] FAIL len v=%h: got %0d, required %0d", v, len, nd + (ng ? 1 : 0));
      end
      checks++;
      if (bsy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bsy_at_done v=%h: got %b, required 0", v, bsy);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_writes v=%h: got %0d pending, required 0", v, sb.size());
      sb.delete();
    end

    if (fin_start && got) begin
      start = 1'b1;
      vi    = 32'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (bsy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL start_in_fin: got bsy=%b, required 0", bsy);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hex = 1'b0; vi = '0; dst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bsy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got bsy=%b done=%b we=%b, required 0 0 0", bsy, done, mem_we);
    end
    checks++;
    if (len !== 6'd0 || mem_a !== '0 || mem_d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_data: got len=%0d a=%h d=%h, required 0 0 0", len, mem_a, mem_d);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_decimal();
    run_conv(1'b0, 32'd123, 17'h100, 50, 1'b0);
    run_conv(1'b0, -32'sd45, 17'h020, 0, 1'b0);
  endtask

  task automatic test_zero();
    run_conv(1'b0, 32'd0, 17'h050, 0, 1'b0);
    run_conv(1'b1, 32'd0, 17'h060, 0, 1'b0);
  endtask

  task automatic test_extreme();
    run_conv(1'b0, 32'h80000000, 17'h200, 0, 1'b0);
    run_conv(1'b0, 32'h7fffffff, 17'h220, 0, 1'b0);
  endtask

  task automatic test_hex();
    run_conv(1'b1, 32'hdeadbeef, 17'h080, 5, 1'b0);
    run_conv(1'b1, 32'hffffffff, 17'h090, 0, 1'b1);
  endtask

  task automatic test_wrap();
    run_conv(1'b1, 32'h00001234, 17'h1fffe, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; hex = 1'b0; vi = 32'd98765; dst = 17'h300;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bsy !== 1'b0 || mem_a !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got bsy=%b a=%h, required bsy=0 a=0", bsy, mem_a);
    end
    repeat (200) @(posedge clk);
    run_conv(1'b0, 32'd7, 17'h040, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_zero();
    test_extreme();
    test_hex();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
